// File: rtl/icache_if.sv
// icache_if: CPU fetch port and block-wide instruction memory port of the icache.
// The master modport is the surrounding system (CPU plus memory); the slave
// modport is the cache itself.
interface icache_if;
    // CPU fetch side
    logic         READ;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    // Instruction memory side
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    modport master (
        output READ, PC, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport slave (
        input  READ, PC, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache, 8 lines of 16 bytes.
// Hits return in the same cycle; a miss stalls the CPU with BUSYWAIT while the
// block is fetched over a busy-wait handshake and installed.
// Optional feature macro: ICACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT.
module icache (
    input  logic        CLK,
    input  logic        RESET,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);
    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_WORDS = 4;
    localparam int IDX_W       = $clog2(NUM_BLOCKS);
    localparam int OFF_W       = $clog2(BLOCK_WORDS);
    localparam int TAG_W       = 3;
    localparam int LINE_W      = 32 * BLOCK_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        UPDATE
    } state_t;

    state_t state;
    state_t next_state;

    // Line storage: data and tag carry no reset, only the valid bits do.
    logic [LINE_W-1:0]      data_array [NUM_BLOCKS];
    logic [TAG_W-1:0]       tag_array  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]  valid;
    logic [TAG_W+IDX_W-1:0] miss_addr;

    // Address split of the presented PC.
    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] pc_index;
    logic [OFF_W-1:0] pc_offset;
    logic             unused_pc_bits;

    assign pc_tag         = bus.PC[9:7];
    assign pc_index       = bus.PC[6:4];
    assign pc_offset      = bus.PC[3:2];
    assign unused_pc_bits = ^{bus.PC[31:10], bus.PC[1:0]};

    // The line being filled is always the latched miss, never the live PC.
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_index;

    assign {fill_tag, fill_index} = miss_addr;

    logic              hit;
    logic              miss;
    logic              fill;
    logic              mem_read;
    logic              busywait;
    logic [LINE_W-1:0] sel_line;

    assign hit      = bus.READ & valid[pc_index] & (tag_array[pc_index] == pc_tag);
    assign sel_line = data_array[pc_index];
    assign miss     = (state == IDLE) & bus.READ & ~hit;
    assign fill     = (state == FETCH) & ~bus.MEM_BUSYWAIT;

    assign bus.INSTRUCTION = hit ? sel_line[{pc_offset, 5'b0} +: 32] : 32'h0;
    assign bus.BUSYWAIT    = busywait;
    assign bus.MEM_READ    = mem_read;
    assign bus.MEM_ADDRESS = mem_read ? miss_addr : '0;

    // State register; reset abandons any fill in flight at once.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        mem_read   = 1'b0;
        busywait   = 1'b0;
        case (state)
            IDLE: begin
                busywait = miss;
                if (miss) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                busywait = 1'b1;
                if (!bus.MEM_BUSYWAIT) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                busywait   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Miss address capture and valid bits.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid     <= '0;
            miss_addr <= '0;
        end else begin
            if (miss) begin
                miss_addr <= bus.PC[9:4];
            end
            if (fill) begin
                valid[fill_index] <= 1'b1;
            end
        end
    end

    // Line install on fill completion.
    // NOTE: data and tag arrays are not reset; valid alone gates their use, so they stay plain RAM.
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_array[fill_index] <= bus.MEM_READDATA;
            tag_array[fill_index]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss counters; the post-fill re-lookup counts as a hit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if ((state == IDLE) && hit && (HIT_COUNT != 16'hFFFF)) begin
                HIT_COUNT <= HIT_COUNT + 16'd1;
            end
            if (miss && (MISS_COUNT != 16'hFFFF)) begin
                MISS_COUNT <= MISS_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache with a block-level reference model.
// The model tracks which block address each line holds and the miss timeline
// (1 lookup cycle, N+1 fetch cycles, 1 update cycle) and is compared against
// the DUT on every falling clock edge.
module tb_icache;
    logic CLK;
    logic RESET;

    icache_if bus ();

`ifdef ICACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    icache dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bus.slave)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT  (HIT_COUNT),
        .MISS_COUNT (MISS_COUNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: word k of block b.
    function automatic logic [31:0] mem_word(input logic [5:0] b, input logic [1:0] k);
        return 32'h00040005 + {b, 20'h0} + {k, 8'h0};
    endfunction

    function automatic logic [127:0] block_data(input logic [5:0] b);
        return {mem_word(b, 2'd3), mem_word(b, 2'd2), mem_word(b, 2'd1), mem_word(b, 2'd0)};
    endfunction

    // Instruction memory: busy for mem_n cycles after MEM_READ rises.
    int mem_n   = 5;
    int mem_cnt = 0;

    always @(posedge CLK) begin
        if (bus.MEM_READ) mem_cnt <= mem_cnt + 1;
        else              mem_cnt <= 0;
    end

    assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mem_cnt < mem_n);
    assign bus.MEM_READDATA = block_data(bus.MEM_ADDRESS);

    // Reference model state.
    bit          m_valid [8];
    logic [5:0]  m_blk   [8];
    int          m_t = 0;
    int          m_n = 0;
    logic [5:0]  m_miss_blk = '0;
    logic [15:0] m_hits = '0;
    logic [15:0] m_misses = '0;

    // Run lengths of BUSYWAIT / MEM_READ high, recorded when they fall.
    int busy_run = 0;
    int mr_run   = 0;
    int last_busy_len = 0;
    int last_mr_len   = 0;

    function automatic bit resident(input logic [31:0] pc);
        return m_valid[pc[6:4]] && (m_blk[pc[6:4]] == pc[9:4]);
    endfunction

    always @(negedge CLK) begin : compare
        bit          hit_m;
        logic [31:0] exp_instr;
        if (!RESET) begin
            check("reset_mem_read", bus.MEM_READ, 0);
            check("reset_busywait", bus.BUSYWAIT, 0);
            check("reset_instruction", bus.INSTRUCTION, 0);
            check("reset_mem_address", bus.MEM_ADDRESS, 0);
`ifdef ICACHE_STATS_EN
            check("reset_hit_count", HIT_COUNT, 0);
            check("reset_miss_count", MISS_COUNT, 0);
`endif
            m_t      = 0;
            m_hits   = '0;
            m_misses = '0;
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        end else begin
`ifdef ICACHE_STATS_EN
            check("hit_count", HIT_COUNT, m_hits);
            check("miss_count", MISS_COUNT, m_misses);
`endif
            if (m_t == 0) begin
                hit_m     = bus.READ && resident(bus.PC);
                exp_instr = hit_m ? mem_word(bus.PC[9:4], bus.PC[3:2]) : 32'h0;
                check("lookup_busywait", bus.BUSYWAIT, bus.READ && !hit_m);
                check("lookup_mem_read", bus.MEM_READ, 0);
                check("lookup_instruction", bus.INSTRUCTION, exp_instr);
                if (hit_m && m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
                if (bus.READ && !hit_m) begin
                    m_miss_blk = bus.PC[9:4];
                    m_n        = mem_n;
                    m_t        = 1;
                    if (m_misses != 16'hFFFF) m_misses = m_misses + 16'd1;
                end
            end else if (m_t <= m_n + 1) begin
                check("fetch_busywait", bus.BUSYWAIT, 1);
                check("fetch_mem_read", bus.MEM_READ, 1);
                check("fetch_mem_address", bus.MEM_ADDRESS, m_miss_blk);
                if (m_t == m_n + 1) begin
                    m_valid[m_miss_blk[2:0]] = 1'b1;
                    m_blk[m_miss_blk[2:0]]   = m_miss_blk;
                end
                m_t++;
            end else begin
                check("update_busywait", bus.BUSYWAIT, 1);
                check("update_mem_read", bus.MEM_READ, 0);
                m_t = 0;
            end
        end
        if (bus.BUSYWAIT) busy_run++;
        else if (busy_run != 0) begin last_busy_len = busy_run; busy_run = 0; end
        if (bus.MEM_READ) mr_run++;
        else if (mr_run != 0) begin last_mr_len = mr_run; mr_run = 0; end
    end

    // Present a new PC right after an edge and settle to mid-cycle.
    task automatic present(input logic [31:0] pc);
        @(posedge CLK); #1;
        bus.PC = pc;
        @(negedge CLK); #1;
    endtask

    // Advance mid-cycle by mid-cycle until the stall clears, bounded.
    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge CLK); #1;
            n++;
        end while (bus.BUSYWAIT && n < budget);
        check({name, "_stall_bound"}, bus.BUSYWAIT, 0);
    endtask

    initial begin
        int n;
        bus.READ = 1'b0;
        bus.PC   = 32'h0;
        RESET    = 1'b1;
        mem_n    = 5;
        #1 RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("init_instruction", bus.INSTRUCTION, 32'h0);
        check("init_busywait", bus.BUSYWAIT, 0);
        check("init_mem_read", bus.MEM_READ, 0);
        check("init_mem_address", bus.MEM_ADDRESS, 0);

        // Cold miss at PC=0, N=5.
        @(posedge CLK); #1;
        RESET    = 1'b1;
        bus.READ = 1'b1;
        bus.PC   = 32'h0;
        @(negedge CLK); #1;
        check("cold_miss_busywait", bus.BUSYWAIT, 1);
        @(negedge CLK); #1;
        check("cold_mem_address", bus.MEM_ADDRESS, 6'h00);
        wait_idle("cold", 20);
        check("cold_busy_cycles", last_busy_len, 8);
        check("cold_mem_read_cycles", last_mr_len, 6);
        check("cold_instruction", bus.INSTRUCTION, 32'h00040005);

        // Sequential hits on the same line.
        present(32'h4);
        check("seq_pc4", bus.INSTRUCTION, 32'h00040105);
        check("seq_pc4_busywait", bus.BUSYWAIT, 0);
        present(32'h8);
        check("seq_pc8", bus.INSTRUCTION, 32'h00040205);
        present(32'hC);
        check("seq_pc12", bus.INSTRUCTION, 32'h00040305);
        check("seq_pc12_mem_read", bus.MEM_READ, 0);
`ifdef ICACHE_STATS_EN
        @(posedge CLK); #1;
        check("stats_hits_after_cold", HIT_COUNT, 16'd4);
        check("stats_misses_after_cold", MISS_COUNT, 16'd1);
`endif

        // Conflict eviction with zero-latency memory.
        mem_n = 0;
        present(32'h80);
        check("conflict_busywait", bus.BUSYWAIT, 1);
        @(negedge CLK); #1;
        check("conflict_mem_address", bus.MEM_ADDRESS, 6'h08);
        wait_idle("conflict", 10);
        check("conflict_busy_cycles", last_busy_len, 3);
        check("conflict_mem_read_cycles", last_mr_len, 1);
        check("conflict_instruction", bus.INSTRUCTION, 32'h00840005);
        present(32'h0);
        check("evicted_busywait", bus.BUSYWAIT, 1);
        @(negedge CLK); #1;
        check("evicted_mem_address", bus.MEM_ADDRESS, 6'h00);
        wait_idle("evicted", 10);
        check("evicted_instruction", bus.INSTRUCTION, 32'h00040005);

        // Reset asserted in the third FETCH cycle.
        mem_n = 5;
        present(32'h30);
        repeat (3) begin @(posedge CLK); #1; end
        check("midfill_mem_read_before", bus.MEM_READ, 1);
        RESET    = 1'b0;
        bus.READ = 1'b0;
        #1;
        check("midfill_mem_read", bus.MEM_READ, 0);
        check("midfill_busywait", bus.BUSYWAIT, 0);
        check("midfill_instruction", bus.INSTRUCTION, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET    = 1'b1;
        bus.READ = 1'b1;
        bus.PC   = 32'h0;
        @(negedge CLK); #1;
        check("postreset_miss", bus.BUSYWAIT, 1);
        @(negedge CLK); #1;
        check("postreset_mem_address", bus.MEM_ADDRESS, 6'h00);
        wait_idle("postreset", 20);
        check("postreset_instruction", bus.INSTRUCTION, 32'h00040005);

        // PC changes during FETCH: the latched line fills, then the new PC misses.
        mem_n = 3;
        present(32'h10);
        @(negedge CLK); #1;
        check("pcchg_first_addr", bus.MEM_ADDRESS, 6'h01);
        @(posedge CLK); #1;
        bus.PC = 32'h20;
        @(negedge CLK); #1;
        check("pcchg_addr_held", bus.MEM_ADDRESS, 6'h01);
        n = 0;
        while (!(bus.MEM_READ && bus.MEM_ADDRESS == 6'h02) && n < 30) begin
            @(negedge CLK); #1;
            n++;
        end
        check("pcchg_second_miss", {25'h0, bus.MEM_READ, bus.MEM_ADDRESS}, {25'h0, 1'b1, 6'h02});
        wait_idle("pcchg", 20);
        check("pcchg_new_instruction", bus.INSTRUCTION, 32'h00240005);
        present(32'h10);
        check("pcchg_line1_filled", bus.INSTRUCTION, 32'h00140005);
        check("pcchg_line1_busywait", bus.BUSYWAIT, 0);

        // READ dropped mid-fill: the fill still completes.
        mem_n = 2;
        present(32'h58);
        @(posedge CLK); #1;
        bus.READ = 1'b0;
        @(negedge CLK); #1;
        check("readlow_fill_stall", bus.BUSYWAIT, 1);
        wait_idle("readlow", 10);
        check("readlow_instruction", bus.INSTRUCTION, 32'h0);
        @(posedge CLK); #1;
        bus.READ = 1'b1;
        @(negedge CLK); #1;
        check("readlow_hit_busywait", bus.BUSYWAIT, 0);
        check("readlow_hit_instruction", bus.INSTRUCTION, 32'h00540205);

`ifdef ICACHE_STATS_EN
        // Long hit run to drive HIT_COUNT into saturation.
        present(32'h0);
        repeat (66000) @(posedge CLK);
        #1;
        check("stats_hit_saturate", HIT_COUNT, 16'hFFFF);
`endif

        @(posedge CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the CPU's PC/INSTRUCTION fetch port and a slow, block-wide instruction memory. It returns hits in the same cycle. On a miss it stalls the CPU with BUSYWAIT, fetches the 16-byte block through a busy-wait handshake, and installs it. It replaces the fixed-delay fetch logic in front of `cpu`.

## Interface
- NUM_BLOCKS, 8: cache lines; index width log2(NUM_BLOCKS)=3.
- BLOCK_WORDS, 4: 32-bit words per line (16 bytes); offset = PC[3:2].
- CLK  in  1  system clock, rising edge.
- RESET  in  1  one clock; reset is asynchronous and active-low.
- READ  in  1  fetch request; CPU holds high except while it is itself in reset.
- PC  in  32  byte address; PC[9:0] used, PC[1:0] ignored, PC[31:10] ignored.
- INSTRUCTION  out  32  fetched word; valid when READ=1 and BUSYWAIT=0.
- BUSYWAIT  out  1  stall to CPU; PC must be held while high.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  6  block address {tag,index} = PC[9:4] of the miss.
- MEM_READDATA  in  128  block; word k at bits [32k+31:32k].
- MEM_BUSYWAIT  in  1  memory busy; must rise combinationally with MEM_READ, fall when MEM_READDATA valid.

## Operation
- Address split: tag PC[9:7], index PC[6:4], offset PC[3:2].
- Storage: data[8]x128, tag[8]x3, valid[8]x1. Valid bits are cleared by reset. Data and tag are not reset.
- Hit = READ & valid[index] & (tag[index]==PC[9:7]). Hit is combinational from PC and registered arrays.
- INSTRUCTION = selected word on hit, else 32'h0.
- FSM states:
  - IDLE: BUSYWAIT = READ & ~hit. On READ & ~hit, latch PC[9:4] into miss_addr and go to FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS=miss_addr, BUSYWAIT=1. On an edge with MEM_BUSYWAIT=0, write MEM_READDATA, tag and valid=1 into the miss_addr line, then go to UPDATE.
  - UPDATE: MEM_READ=0, BUSYWAIT=1. Unconditionally return to IDLE on the next edge.
- Back in IDLE the lookup is repeated against the current PC. It normally hits.
- Replacement: the line at index is overwritten unconditionally. There is no write path.
- PC change during FETCH/UPDATE (protocol violation): the fill completes for the latched miss_addr. The new PC is then looked up in IDLE and may miss again.
- READ low: BUSYWAIT=0 in IDLE. An in-progress fill still completes.

## Timing
- Reset values: state=IDLE, MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=0, all valid=0.
- Reset takes effect immediately, asynchronously. An in-flight FETCH is abandoned and MEM_READ drops the same instant. Memory must tolerate an abandoned read.
- Hit latency: 0 cycles. INSTRUCTION and BUSYWAIT=0 settle in the cycle PC is presented.
- Miss latency: memory holds MEM_BUSYWAIT high N cycles after MEM_READ rises. BUSYWAIT is then high for exactly N+3 cycles: the miss cycle, N FETCH busy cycles plus 1 completion cycle, then UPDATE. N=0 gives 3 cycles.
- MEM_READ is high for N+1 cycles and is a level, not a pulse.
- MEM_ADDRESS is stable for the whole of FETCH.

## Configuration
- ICACHE_STATS_EN defined: adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - HIT_COUNT increments on each edge in IDLE with hit.
  - MISS_COUNT increments on each IDLE→FETCH transition.
  - The post-fill re-lookup counts as a hit.
- ICACHE_STATS_EN undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Test plan
- Cold miss: reset, release, READ=1, PC=0, memory N=5, block word0=32'h00040005.
  - Expected: MEM_ADDRESS=0, MEM_READ high 6 cycles, BUSYWAIT high 8 cycles, then INSTRUCTION=32'h00040005.
- Sequential hits: after the cold miss, PC=4,8,12 on consecutive cycles.
  - Expected: BUSYWAIT=0, MEM_READ=0, words 1..3 returned in-cycle.
- Conflict eviction: PC=0x80 (index 0, tag 1).
  - Expected: miss, MEM_ADDRESS=6'h08. Then PC=0 misses again with MEM_ADDRESS=0.
- Reset mid-fill: assert RESET on the 3rd FETCH cycle.
  - Expected: MEM_READ, BUSYWAIT and INSTRUCTION go to 0 immediately. After release, PC=0 misses.
- PC change mid-fill: PC 0x10→0x20 during FETCH.
  - Expected: line 1 filled from 6'h01, then a second miss with MEM_ADDRESS=6'h02.
- Stats (ICACHE_STATS_EN): cold miss then 3 hits.
  - Expected: MISS_COUNT=1, HIT_COUNT=4 (post-fill hit plus 3). Preload HIT_COUNT near 16'hFFFF via a long hit run and check it saturates at 16'hFFFF.
